// File: rtl/mdu_pkg.sv
// Shared encodings and sizing helpers for the HI/LO multiply/divide sequencer.
// Covers op/state encodings, hilo_we bit positions and busy-counter width.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int WE_LO = 0;
    localparam int WE_HI = 1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Counter must be able to hold the longer of the two busy windows.
    function automatic int cnt_width(input int mult_cycles, input int div_cycles);
        int mx;
        mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(mx + 1);
    endfunction

    localparam int CNT_W = cnt_width(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/multu/div/divu on latched operands; zero latency.
// No handshake: outputs follow inputs; div0 flags a zero divisor for div/divu.
import mdu_pkg::*;

module mdu_arith (
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        div0
);

    logic [63:0] prod;
    logic        is_signed_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        div0          = op[1] & (b == 32'd0);
        is_signed_div = (op == OP_DIV);

        // Sign-extending both operands makes the low 64 bits the signed product.
        if (op == OP_MULT)
            prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else
            prod = {32'd0, a} * {32'd0, b};

        // Signed division on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        a_neg  = is_signed_div & a[31];
        b_neg  = is_signed_div & b[31];
        a_mag  = a_neg ? (32'd0 - a) : a;
        b_mag  = b_neg ? (32'd0 - b) : b;
        b_safe = div0 ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;

        if (op[1]) begin
            hi_next = rem;
            lo_next = quot;
        end else begin
            hi_next = prod[63:32];
            lo_next = prod[31:0];
        end
    end

endmodule

// File: rtl/mdu_sched.sv
// HI/LO owner: latches operands on start, commits after MULT_CYCLES/DIV_CYCLES busy cycles.
// No backpressure taken; stall_req holds off D-stage HI/LO users. MDU_DIV0_FAST_EN: 1-cycle div-by-zero.
import mdu_pkg::*;

module mdu_sched #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  hilo_we,
    input  logic [31:0] wdata,
    input  logic        rd_sel,
    input  logic        flush,
    input  logic        ismu_d,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        stall_req
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE     = CW'(1);

    mdu_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    mdu_op_e       op_q;
    logic [31:0]   a_q, b_q;
    logic [31:0]   hi, lo, hi_d, lo_d;
    logic [31:0]   hi_next, lo_next;
    logic          div0;
    logic          load;
    logic          commit;
    logic          we_ok;

    mdu_arith u_arith (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .hi_next (hi_next),
        .lo_next (lo_next),
        .div0    (div0)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_nxt = ST_RUN;
                    load      = 1'b1;
                    cnt_nxt   = op[1] ? DIV_LD : MULT_LD;
`ifdef MDU_DIV0_FAST_EN
                    if (op[1] && (b == 32'd0))
                        cnt_nxt = ONE;
`endif
                end
            end
            ST_RUN: begin
                cnt_nxt = cnt - ONE;
                if (cnt == ONE) begin
                    state_nxt = ST_IDLE;
                    commit    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Direct HI/LO writes only when idle and no real start this cycle (start wins).
    always_comb begin
        we_ok = (state == ST_IDLE) && !start && !flush;
        hi_d  = hi;
        lo_d  = lo;
        if (commit && !div0) begin
            hi_d = hi_next;
            lo_d = lo_next;
        end else if (we_ok) begin
            if (hilo_we[WE_HI]) hi_d = wdata;
            if (hilo_we[WE_LO]) lo_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_d;
            lo    <= lo_d;
            if (load) begin
                op_q <= mdu_op_e'(op);
                a_q  <= a;
                b_q  <= b;
            end
        end
    end

    assign busy      = (state == ST_RUN);
    assign stall_req = ismu_d & (busy | start);
    assign rdata     = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_sched.sv
// Directed plus randomized checks of mdu_sched against a cycle-level HI/LO reference model.
module tb_mdu_sched;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_DIV0_FAST_EN
    localparam int DIV0_N = 1;
`else
    localparam int DIV0_N = DC;
`endif

    logic        clk = 1'b0;
    logic        reset, start, flush, ismu_d, rd_sel;
    logic [1:0]  op, hilo_we;
    logic [31:0] a, b, wdata, rdata;
    logic        busy, stall_req;

    mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hilo_we   (hilo_we),
        .wdata     (wdata),
        .rd_sel    (rd_sel),
        .flush     (flush),
        .ismu_d    (ismu_d),
        .rdata     (rdata),
        .busy      (busy),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] p_hi = '0, p_lo = '0;
    bit          p_div0 = 1'b0;
    int          rem = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers; caller excludes zero divisors.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'b00: res = sx * sy;
            2'b01: res = ux * uy;
            2'b10: begin
                sq  = sx / sy;
                sr  = sx % sy;
                res = {sr[31:0], sq[31:0]};
            end
            default: begin
                uq  = ux / uy;
                ur  = ux % uy;
                res = {ur[31:0], uq[31:0]};
            end
        endcase
        return res;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            rem  = 0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0 && !p_div0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start && !flush) begin
            p_div0 = op[1] && (b == 32'd0);
            if (!p_div0) {p_hi, p_lo} = ref_result(op, a, b);
            rem = op[1] ? (p_div0 ? DIV0_N : DC) : MC;
        end else if (!flush) begin
            if (hilo_we[0]) m_lo = wdata;
            if (hilo_we[1]) m_hi = wdata;
        end
    endtask

    task automatic tick(input string tag);
        logic exp_stall;
        #1;
        exp_stall = ismu_d & ((rem > 0) | start);
        chk({tag, " stall_req"}, {31'd0, stall_req}, {31'd0, exp_stall});
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, " busy"}, {31'd0, busy}, {31'd0, rem > 0});
        rd_sel = 1'b0;
        #1 chk({tag, " lo"}, rdata, m_lo);
        rd_sel = 1'b1;
        #1 chk({tag, " hi"}, rdata, m_hi);
    endtask

    task automatic expect_hilo(input string tag, input logic [31:0] h, input logic [31:0] l);
        rd_sel = 1'b0;
        #1 chk({tag, " LO const"}, rdata, l);
        rd_sel = 1'b1;
        #1 chk({tag, " HI const"}, rdata, h);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; start = 1'b0; flush = 1'b0; ismu_d = 1'b0; hilo_we = 2'b00;
    endtask

    initial begin
        idle_inputs();
        op = 2'b00; a = '0; b = '0; wdata = '0; rd_sel = 1'b0;

        reset = 1'b1;
        tick("reset");
        tick("reset");
        reset = 1'b0;
        chk("reset busy const", {31'd0, busy}, 32'd0);
        expect_hilo("reset", 32'h0, 32'h0);

        op = 2'b00; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
        tick("mult start");
        start = 1'b0;
        repeat (MC) tick("mult run");
        chk("mult busy done", {31'd0, busy}, 32'd0);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        tick("multu start");
        start = 1'b0;
        repeat (MC) tick("multu run");
        expect_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1; ismu_d = 1'b1;
        #1 chk("div stall in start cycle", {31'd0, stall_req}, 32'd1);
        tick("div start");
        start = 1'b0;
        repeat (3) tick("div run");
        chk("div stall while busy", {31'd0, stall_req}, 32'd1);
        repeat (DC - 3) tick("div run");
        tick("div after");
        chk("div stall released", {31'd0, stall_req}, 32'd0);
        ismu_d = 1'b0;
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        hilo_we = 2'b01; wdata = 32'h0000_1234;
        tick("mtlo");
        hilo_we = 2'b00;
        op = 2'b10; a = 32'd5; b = 32'd0; start = 1'b1;
        tick("div0 start");
        start = 1'b0;
        repeat (DIV0_N) tick("div0 run");
        chk("div0 busy done", {31'd0, busy}, 32'd0);
        expect_hilo("div0", 32'hFFFF_FFFF, 32'h0000_1234);

        op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
        tick("flushed start");
        start = 1'b0; flush = 1'b0;
        chk("flushed start busy", {31'd0, busy}, 32'd0);
        tick("flushed idle");
        expect_hilo("flushed start", 32'hFFFF_FFFF, 32'h0000_1234);

        hilo_we = 2'b10; wdata = 32'hDEAD_BEEF; flush = 1'b1;
        tick("flushed mthi");
        flush = 1'b0; hilo_we = 2'b00;
        expect_hilo("flushed mthi", 32'hFFFF_FFFF, 32'h0000_1234);
        hilo_we = 2'b10;
        tick("mthi");
        hilo_we = 2'b00;
        expect_hilo("mthi", 32'hDEAD_BEEF, 32'h0000_1234);

        op = 2'b00; a = 32'd7; b = 32'd9; start = 1'b1;
        tick("mid reset start");
        start = 1'b0;
        tick("mid reset run");
        tick("mid reset run");
        reset = 1'b1;
        tick("mid reset");
        reset = 1'b0;
        chk("mid reset busy const", {31'd0, busy}, 32'd0);
        expect_hilo("mid reset", 32'h0, 32'h0);
        op = 2'b01; a = 32'd10; b = 32'd20; start = 1'b1;
        tick("post reset start");
        start = 1'b0;
        repeat (MC - 1) tick("post reset run");
        chk("post reset still busy", {31'd0, busy}, 32'd1);
        tick("post reset run");
        expect_hilo("post reset", 32'h0, 32'd200);

        for (int i = 0; i < 500; i++) begin
            reset   = ($urandom_range(0, 79) == 0);
            start   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 7) == 0);
            ismu_d  = $urandom_range(0, 1) == 1;
            op      = 2'($urandom_range(0, 3));
            hilo_we = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            wdata   = $urandom;
            a       = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
